// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

   localparam int PROGRAM_ADDRESS_WIDTH = 6;
   localparam logic RESET = 1'b1;
   localparam int INSTR_WIDTH = 32;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;

   typedef struct packed {
      logic [PROGRAM_ADDRESS_WIDTH-1:0] pc;
      logic [INSTR_WIDTH-1:0]           instr;
   } if_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with push/pop/flush; a push into a
// full queue is accepted when a pop happens in the same cycle.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  if_entry_t     wr_data,
   output if_entry_t     rd_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   if_entry_t     mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; an empty queue presents zeros instead.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: issues PCs to imem, queues responses in order, hands
// {pc, instr} to decode. Optional counters: define FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter logic [PROGRAM_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             imem_req_valid,
   input  logic                             imem_req_ready,
   output logic [PROGRAM_ADDRESS_WIDTH-1:0] imem_req_addr,
   input  logic                             imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0]           imem_rsp_data,
   input  logic                             redirect_valid,
   input  logic [PROGRAM_ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                             if_valid,
   input  logic                             if_ready,
   output logic [INSTR_WIDTH-1:0]           if_instr,
   output logic [PROGRAM_ADDRESS_WIDTH-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                      perf_fetched,
   output logic [31:0]                      perf_stall
`endif
);

   localparam int PAW = PROGRAM_ADDRESS_WIDTH;
   localparam int QCW = $clog2(QUEUE_DEPTH + 1);
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

   fetch_state_t   state_q, state_d;
   logic [PAW-1:0] fetch_pc_q, fetch_pc_d;
   logic [OW-1:0]  stale_q, stale_d;
   logic [OW-1:0]  out_after;
   logic [QCW-1:0] q_count;
   logic [OW-1:0]  tag_count;
   logic           q_full, q_empty, tag_full, tag_empty;
   logic           req_valid, req_fire, rsp_stale, push, pop;
   if_entry_t      q_wr, q_head, tag_wr, tag_head;
   logic           unused_bits;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      stale_d    = stale_q;
      // Credit rule: a granted request always has a queue slot waiting for it.
      req_valid  = (state_q == RUN) && !redirect_valid
                   && (int'(tag_count) < MAX_OUTSTANDING)
                   && (int'(q_count) + int'(tag_count) < QUEUE_DEPTH);
      req_fire   = req_valid && imem_req_ready;
      rsp_stale  = (stale_q != '0);
      push       = imem_rsp_valid && !rsp_stale && !redirect_valid;
      out_after  = tag_count + OW'(req_fire) - OW'(imem_rsp_valid);
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[PAW-1:2], 2'b00};
         stale_d    = out_after;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + PAW'(4);
         if (imem_rsp_valid && rsp_stale) stale_d = stale_q - OW'(1);
      end
      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (redirect_valid && out_after != '0) state_d = DRAIN;
         DRAIN:   if (!redirect_valid && stale_q == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RESET) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         stale_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         stale_q    <= stale_d;
      end
   end

   // Tag FIFO remembers each request PC until its response returns, stale or not.
   assign tag_wr = '{pc: fetch_pc_q, instr: '0};
   assign q_wr   = '{pc: tag_head.pc, instr: imem_rsp_data};
   assign pop    = if_valid && if_ready;

   fetch_queue #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk(clk), .rst(rst), .push(req_fire), .pop(imem_rsp_valid), .flush(1'b0),
      .wr_data(tag_wr), .rd_data(tag_head), .count(tag_count),
      .full(tag_full), .empty(tag_empty)
   );

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_instr_queue (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect_valid),
      .wr_data(q_wr), .rd_data(q_head), .count(q_count),
      .full(q_full), .empty(q_empty)
   );

   assign imem_req_valid = req_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign if_valid       = !q_empty;
   assign if_pc          = q_head.pc;
   assign if_instr       = q_head.instr;
   assign unused_bits    = ^{tag_head.instr, tag_full, tag_empty, q_full};

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + 32'(push);
      perf_stall_d   = perf_stall_q + 32'(if_valid && !if_ready);
   end

   always_ff @(posedge clk) begin
      if (rst == RESET) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with adjustable latency and
// an in-order PC scoreboard on the decode side.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int PAW = PROGRAM_ADDRESS_WIDTH;
   localparam logic [PAW-1:0] TB_RESET_PC = '0;

   logic           clk = 1'b0;
   logic           rst;
   logic           imem_req_valid, imem_req_ready;
   logic [PAW-1:0] imem_req_addr;
   logic           imem_rsp_valid;
   logic [31:0]    imem_rsp_data;
   logic           redirect_valid;
   logic [PAW-1:0] redirect_pc;
   logic           if_valid, if_ready;
   logic [31:0]    if_instr;
   logic [PAW-1:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]    perf_fetched, perf_stall;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.QUEUE_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(TB_RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
   );

   typedef struct {
      logic [PAW-1:0] addr;
      int             due;
   } pend_t;

   pend_t          pend[$];
   int             cyc, lat;
   int             total, bad;
   int             n_fire, n_pop, n_rsp, n_stall;
   logic [PAW-1:0] exp_pc, exp_req, last_req, first_pc;
   logic           want_first, wrap_seen;

   function automatic logic [31:0] imem_word(input logic [PAW-1:0] a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: starts and ends at a falling edge, inputs already set by caller.
   task automatic cycle();
      logic           fire, popv, rsp;
      logic [PAW-1:0] a_save;
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = imem_word(pend[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
      rsp    = imem_rsp_valid && !rst;
      fire   = imem_req_valid && imem_req_ready && !rst;
      popv   = if_valid && if_ready && !rst && !redirect_valid;
      a_save = imem_req_addr;
      if (fire) begin
         check_val("req_addr", 32'(imem_req_addr), 32'(exp_req));
         if (last_req == 6'h3C && imem_req_addr == 6'h00) wrap_seen = 1'b1;
         last_req = imem_req_addr;
         exp_req  = exp_req + 6'd4;
         n_fire++;
      end
      if (popv) begin
         check_val("pop_pc", 32'(if_pc), 32'(exp_pc));
         check_val("pop_instr", if_instr, imem_word(exp_pc));
         if (want_first) begin
            first_pc   = if_pc;
            want_first = 1'b0;
         end
         exp_pc = exp_pc + 6'd4;
         n_pop++;
      end
      if (rsp && !redirect_valid) n_rsp++;
      if (if_valid && !if_ready && !rst) n_stall++;
      if (redirect_valid) begin
         exp_pc  = {redirect_pc[PAW-1:2], 2'b00};
         exp_req = {redirect_pc[PAW-1:2], 2'b00};
      end
      @(posedge clk);
      cyc++;
      if (rsp) void'(pend.pop_front());
      if (fire) pend.push_back('{addr: a_save, due: cyc - 1 + lat});
      if (rst) begin
         pend.delete();
         exp_pc  = TB_RESET_PC;
         exp_req = TB_RESET_PC;
         n_rsp   = 0;
         n_stall = 0;
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_if_valid"}, 32'(if_valid), 32'd0);
      check_val({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check_val({tag, "_req_addr"}, 32'(imem_req_addr), 32'(TB_RESET_PC));
      check_val({tag, "_if_instr"}, if_instr, 32'd0);
      check_val({tag, "_if_pc"}, 32'(if_pc), 32'd0);
   endtask

   initial begin
      logic [PAW-1:0] h_pc;
      logic [31:0]    h_instr;
      int             unstable, p0;
      logic           found;

      total = 0; bad = 0; cyc = 0; lat = 1;
      n_fire = 0; n_pop = 0; n_rsp = 0; n_stall = 0;
      exp_pc = TB_RESET_PC; exp_req = TB_RESET_PC; last_req = '0; first_pc = '0;
      want_first = 1'b0; wrap_seen = 1'b0;
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      @(negedge clk);

      // Reset state
      cycle();
      cycle();
      check_reset_outputs("reset");
      rst = 1'b0;

      // 1: streaming with 1-cycle imem, decode always ready
      imem_req_ready = 1'b1;
      if_ready = 1'b1;
      for (int i = 0; i < 16; i++) cycle();
      check_val("t1_pops", 32'(n_pop), 32'd13);

      // 2: decode back-pressure fills the queue and freezes the head
      if_ready = 1'b0;
      h_pc = if_pc;
      h_instr = if_instr;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (if_pc !== h_pc || if_instr !== h_instr) unstable++;
      end
      check_val("t2_head_stable", 32'(unstable), 32'd0);
      check_val("t2_buffered", 32'(n_fire - n_pop), 32'd4);
      check_val("t2_no_req", 32'(imem_req_valid), 32'd0);
      check_val("t2_valid", 32'(if_valid), 32'd1);
      if_ready = 1'b1;
      for (int i = 0; i < 12; i++) cycle();

      // 3: redirect with two requests in flight
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (pend.size() == 2 && pend[0].due > cyc) found = 1'b1;
         else cycle();
      end
      check_val("t3_found", 32'(found), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 6'h23;
      want_first = 1'b1;
      cycle();
      redirect_valid = 1'b0;
      check_val("t3_flush", 32'(if_valid), 32'd0);
      check_val("t3_drain_noreq", 32'(imem_req_valid), 32'd0);
      p0 = n_pop;
      for (int i = 0; i < 20; i++) cycle();
      check_val("t3_progress", 32'(n_pop > p0), 32'd1);
      check_val("t3_first_pc", 32'(first_pc), 32'h20);

      // 4: fetch address wraps past the top of the address space
      lat = 1;
      redirect_valid = 1'b1;
      redirect_pc = 6'h34;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 16; i++) cycle();
      check_val("t4_wrap", 32'(wrap_seen), 32'd1);

      // 5: redirect coinciding with a response and a pop, credits exhausted
      lat = 2;
      if_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (pend.size() == 1 && pend[0].due <= cyc && !imem_req_valid && if_valid) found = 1'b1;
         else cycle();
      end
      check_val("t5_found", 32'(found), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc = 6'h10;
      if_ready = 1'b1;
      want_first = 1'b1;
      cycle();
      redirect_valid = 1'b0;
      check_val("t5_flush", 32'(if_valid), 32'd0);
      for (int i = 0; i < 15; i++) cycle();
      check_val("t5_first_pc", 32'(first_pc), 32'h10);

      // 6: reset in the middle of traffic
      lat = 1;
      for (int i = 0; i < 5; i++) cycle();
      rst = 1'b1;
      cycle();
      check_reset_outputs("t6");
`ifdef FETCH_PERF_CNT_EN
      check_val("t6_perf_fetched0", perf_fetched, 32'd0);
      check_val("t6_perf_stall0", perf_stall, 32'd0);
`endif
      rst = 1'b0;
      want_first = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if_ready = (i % 3 != 0);
         cycle();
      end
      check_val("t6_first_pc", 32'(first_pc), 32'(TB_RESET_PC));
`ifdef FETCH_PERF_CNT_EN
      check_val("t6_perf_fetched", perf_fetched, 32'(n_rsp));
      check_val("t6_perf_stall", perf_stall, 32'(n_stall));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
